// File: rtl/ysyx_24120013_ctrl_pkg.sv
// ysyx_24120013_ctrl_pkg
//   Shared encodings for the NPC sequencing controller:
//   - IDU instruction-class commands;
//   - FSM state encodings (also exported on the debug `state` port);
//   - halt-reason codes.
package ysyx_24120013_ctrl_pkg;

  localparam logic [2:0] CMD_INVALID = 3'd0;
  localparam logic [2:0] CMD_ALU     = 3'd1;
  localparam logic [2:0] CMD_LOAD    = 3'd2;
  localparam logic [2:0] CMD_STORE   = 3'd3;
  localparam logic [2:0] CMD_BRANCH  = 3'd4;
  localparam logic [2:0] CMD_JUMP    = 3'd5;
  localparam logic [2:0] CMD_EBREAK  = 3'd6;
  localparam logic [2:0] CMD_RSVD    = 3'd7;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_HALT   = 3'd6
  } state_t;

  localparam logic [1:0] HALT_NONE    = 2'd0;
  localparam logic [1:0] HALT_EBREAK  = 2'd1;
  localparam logic [1:0] HALT_ILLEGAL = 2'd2;
  localparam logic [1:0] HALT_LSU_TO  = 2'd3;

endpackage

// File: rtl/ysyx_24120013_watchdog.sv
// ysyx_24120013_watchdog
//   Saturating wait counter with clear/enable and an expire flag.
//   Ports:
//     clk, rst  - clock, asynchronous active-low reset
//     clr       - clear counter to 0 (has priority over en)
//     en        - count one wait cycle
//     expired   - counter has reached LIMIT (never set when LIMIT == 0)
//   The counter stops at LIMIT so it can never wrap.
module ysyx_24120013_watchdog #(
  parameter int LIMIT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  // LIMIT == 0 still needs a 1-bit register to stay legal.
  localparam int CW = (LIMIT < 1) ? 1 : $clog2(LIMIT + 1);
  localparam logic [CW-1:0] LIM = CW'(LIMIT);

  logic [CW-1:0] cnt_q;
  logic          at_lim;

  assign at_lim  = (cnt_q == LIM);
  assign expired = (LIMIT != 0) && at_lim;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en && !at_lim) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

endmodule

// File: rtl/ysyx_24120013_seq_ctrl.sv
// ysyx_24120013_seq_ctrl
//   Multi-cycle sequencing controller: IDLE -> FETCH -> DECODE -> EXEC
//   [-> MEM] -> WB -> FETCH ..., with HALT on ebreak, illegal command or
//   LSU watchdog timeout. All outputs decode from registered state.
//   Ports:
//     clk, rst        - clock, asynchronous active-low reset
//     start           - leave IDLE
//     ifu_req/ifu_ack - fetch handshake
//     idu_cmd         - instruction class, latched in DECODE
//     exu_en          - one-cycle execute strobe
//     lsu_req/lsu_we/lsu_ack - memory handshake (lsu_we = store)
//     rf_we, pc_we    - writeback enables
//     halt, halt_code - sticky halt and its reason
//     state           - current FSM state (debug)
//     cycle_cnt, instret_cnt - perf counters, only with
//                       YSYX_24120013_PERF_EN defined
module ysyx_24120013_seq_ctrl
  import ysyx_24120013_ctrl_pkg::*;
#(
  parameter int CMD_WIDTH   = 3,
  parameter int LSU_TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic                 ifu_req,
  input  logic                 ifu_ack,
  input  logic [CMD_WIDTH-1:0] idu_cmd,
  output logic                 exu_en,
  output logic                 lsu_req,
  output logic                 lsu_we,
  input  logic                 lsu_ack,
  output logic                 rf_we,
  output logic                 pc_we,
  output logic                 halt,
  output logic [1:0]           halt_code,
  output logic [2:0]           state
`ifdef YSYX_24120013_PERF_EN
  ,
  output logic [63:0]          cycle_cnt,
  output logic [63:0]          instret_cnt
`endif
);

  localparam logic [CMD_WIDTH-1:0] C_ALU    = CMD_WIDTH'(CMD_ALU);
  localparam logic [CMD_WIDTH-1:0] C_LOAD   = CMD_WIDTH'(CMD_LOAD);
  localparam logic [CMD_WIDTH-1:0] C_STORE  = CMD_WIDTH'(CMD_STORE);
  localparam logic [CMD_WIDTH-1:0] C_BRANCH = CMD_WIDTH'(CMD_BRANCH);
  localparam logic [CMD_WIDTH-1:0] C_JUMP   = CMD_WIDTH'(CMD_JUMP);
  localparam logic [CMD_WIDTH-1:0] C_EBREAK = CMD_WIDTH'(CMD_EBREAK);

  state_t               state_q, state_nxt;
  logic [1:0]           halt_code_q, halt_code_nxt;
  logic [CMD_WIDTH-1:0] cmd_q;
  logic                 wd_expired;

  // Counter runs only while in MEM; any other state holds it cleared,
  // so every MEM entry starts from zero.
  ysyx_24120013_watchdog #(
    .LIMIT (LSU_TIMEOUT)
  ) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .clr     (state_q != ST_MEM),
    .en      ((state_q == ST_MEM) && !lsu_ack),
    .expired (wd_expired)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      halt_code_q <= HALT_NONE;
      cmd_q       <= '0;
    end else begin
      state_q     <= state_nxt;
      halt_code_q <= halt_code_nxt;
      if (state_q == ST_DECODE) cmd_q <= idu_cmd;
    end
  end

  always_comb begin
    state_nxt     = state_q;
    halt_code_nxt = halt_code_q;
    case (state_q)
      ST_IDLE:   if (start) state_nxt = ST_FETCH;
      ST_FETCH:  if (ifu_ack) state_nxt = ST_DECODE;
      ST_DECODE: begin
        // Decision uses the live command; cmd_q is loaded this same edge.
        if (idu_cmd == C_EBREAK) begin
          state_nxt     = ST_HALT;
          halt_code_nxt = HALT_EBREAK;
        end else if (idu_cmd == C_ALU  || idu_cmd == C_LOAD   ||
                     idu_cmd == C_STORE || idu_cmd == C_BRANCH ||
                     idu_cmd == C_JUMP) begin
          state_nxt = ST_EXEC;
        end else begin
          state_nxt     = ST_HALT;
          halt_code_nxt = HALT_ILLEGAL;
        end
      end
      ST_EXEC:   state_nxt = (cmd_q == C_LOAD || cmd_q == C_STORE) ? ST_MEM : ST_WB;
      ST_MEM: begin
        // A late ack in the expiring cycle still completes the access.
        if (lsu_ack) begin
          state_nxt = ST_WB;
        end else if (wd_expired) begin
          state_nxt     = ST_HALT;
          halt_code_nxt = HALT_LSU_TO;
        end
      end
      ST_WB:     state_nxt = ST_FETCH;
      ST_HALT:   state_nxt = ST_HALT;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    ifu_req = (state_q == ST_FETCH);
    exu_en  = (state_q == ST_EXEC);
    lsu_req = (state_q == ST_MEM);
    lsu_we  = (state_q == ST_MEM) && (cmd_q == C_STORE);
    pc_we   = (state_q == ST_WB);
    rf_we   = (state_q == ST_WB) &&
              (cmd_q == C_ALU || cmd_q == C_LOAD || cmd_q == C_JUMP);
    halt    = (state_q == ST_HALT);
  end

  assign halt_code = halt_code_q;
  assign state     = state_q;

`ifdef YSYX_24120013_PERF_EN
  logic [63:0] cycle_q, instret_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cycle_q   <= '0;
      instret_q <= '0;
    end else begin
      if (state_q != ST_IDLE && state_q != ST_HALT) cycle_q <= cycle_q + 64'd1;
      if (state_q == ST_WB) instret_q <= instret_q + 64'd1;
    end
  end

  assign cycle_cnt   = cycle_q;
  assign instret_cnt = instret_q;
`endif

endmodule

// File: tb/tb_ysyx_24120013_seq_ctrl.sv
module tb_ysyx_24120013_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        ifu_req;
  logic        ifu_ack;
  logic [2:0]  idu_cmd;
  logic        exu_en;
  logic        lsu_req;
  logic        lsu_we;
  logic        lsu_ack;
  logic        rf_we;
  logic        pc_we;
  logic        halt;
  logic [1:0]  halt_code;
  logic [2:0]  state;
`ifdef YSYX_24120013_PERF_EN
  logic [63:0] cycle_cnt;
  logic [63:0] instret_cnt;
`endif

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  ysyx_24120013_seq_ctrl #(
    .CMD_WIDTH   (3),
    .LSU_TIMEOUT (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .ifu_req   (ifu_req),
    .ifu_ack   (ifu_ack),
    .idu_cmd   (idu_cmd),
    .exu_en    (exu_en),
    .lsu_req   (lsu_req),
    .lsu_we    (lsu_we),
    .lsu_ack   (lsu_ack),
    .rf_we     (rf_we),
    .pc_we     (pc_we),
    .halt      (halt),
    .halt_code (halt_code),
    .state     (state)
`ifdef YSYX_24120013_PERF_EN
    ,
    .cycle_cnt   (cycle_cnt),
    .instret_cnt (instret_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Outputs sampled and inputs changed on the falling edge.
  task automatic tick();
    @(negedge clk);
  endtask

  // Concatenation of every 1-bit output plus code: {ifu,exu,lsu,we,rf,pc,halt,code}
  function automatic logic [8:0] outs();
    return {ifu_req, exu_en, lsu_req, lsu_we, rf_we, pc_we, halt, halt_code};
  endfunction

  task automatic do_reset();
    rst = 1'b0; start = 1'b0; ifu_ack = 1'b0; lsu_ack = 1'b0; idu_cmd = 3'd0;
    tick(); tick();
    rst = 1'b1;
  endtask

  // From IDLE: pulse start and land in FETCH with ifu_ack held high.
  task automatic begin_run(input logic [2:0] cmd);
    start = 1'b1; ifu_ack = 1'b1; idu_cmd = cmd;
    tick();
    start = 1'b0;
  endtask

  initial begin
    do_reset();
    chk("reset_state", state, 3'd0);
    chk("reset_outs", outs(), 9'd0);

    // ALU instruction: 1,2,3,5,1
    begin_run(3'd1);
    chk("alu_fetch", {state, outs()}, {3'd1, 9'b1_0_0_0_0_0_0_00});
    tick(); chk("alu_decode", {state, outs()}, {3'd2, 9'd0});
    tick(); chk("alu_exec", {state, outs()}, {3'd3, 9'b0_1_0_0_0_0_0_00});
    tick(); chk("alu_wb", {state, outs()}, {3'd5, 9'b0_0_0_0_1_1_0_00});
    tick(); chk("alu_refetch", {state, outs()}, {3'd1, 9'b1_0_0_0_0_0_0_00});

    // STORE with ack on 3rd MEM cycle
    idu_cmd = 3'd3;
    tick(); tick();
    tick(); chk("st_mem1", {state, outs()}, {3'd4, 9'b0_0_1_1_0_0_0_00});
    tick(); chk("st_mem2", {state, outs()}, {3'd4, 9'b0_0_1_1_0_0_0_00});
    tick(); chk("st_mem3", {state, outs()}, {3'd4, 9'b0_0_1_1_0_0_0_00});
    lsu_ack = 1'b1;
    tick(); chk("st_wb", {state, outs()}, {3'd5, 9'b0_0_0_0_0_1_0_00});
    lsu_ack = 1'b0;
    tick(); chk("st_refetch", state, 3'd1);

    // LOAD, ack never: halt code 3 after 5 MEM cycles
    idu_cmd = 3'd2;
    tick(); tick();
    for (int i = 0; i < 5; i++) begin
      tick(); chk("ld_to_mem", {state, lsu_req, lsu_we}, {3'd4, 2'b10});
    end
    tick(); chk("ld_to_halt", {state, outs()}, {3'd6, 9'b0_0_0_0_0_0_1_11});

    // LOAD, ack in 5th MEM cycle wins
    do_reset();
    chk("reset_clears_halt", {state, outs()}, {3'd0, 9'd0});
    begin_run(3'd2);
    tick(); tick();
    for (int i = 0; i < 5; i++) begin
      tick(); chk("ld_ack_mem", state, 3'd4);
    end
    lsu_ack = 1'b1;
    tick(); chk("ld_ack_wb", {state, outs()}, {3'd5, 9'b0_0_0_0_1_1_0_00});
    lsu_ack = 1'b0;

    // EBREAK then 20 cycles of start/ifu_ack pressure
    idu_cmd = 3'd6;
    tick(); chk("eb_fetch", state, 3'd1);
    tick(); chk("eb_decode", state, 3'd2);
    tick(); chk("eb_halt", {state, outs()}, {3'd6, 9'b0_0_0_0_0_0_1_01});
    start = 1'b1; ifu_ack = 1'b1; lsu_ack = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick(); chk("eb_hold", {state, outs()}, {3'd6, 9'b0_0_0_0_0_0_1_01});
    end

    // Reserved command 7: illegal, no exu_en
    do_reset();
    begin_run(3'd7);
    tick(); chk("rsvd_decode", {state, exu_en}, {3'd2, 1'b0});
    tick(); chk("rsvd_halt", {state, outs()}, {3'd6, 9'b0_0_0_0_0_0_1_10});

    // INVALID command 0
    do_reset();
    begin_run(3'd0);
    tick(); tick(); chk("inv_halt", {state, outs()}, {3'd6, 9'b0_0_0_0_0_0_1_10});

    // Asynchronous reset in MEM
    do_reset();
    begin_run(3'd3);
    ifu_ack = 1'b1;
    tick(); tick(); tick();
    chk("rst_pre_mem", {state, lsu_req}, {3'd4, 1'b1});
    #2 rst = 1'b0;
    #1 chk("rst_async", {state, outs()}, {3'd0, 9'd0});
    tick(); rst = 1'b1;
    tick(); chk("rst_stays_idle", state, 3'd0);

`ifdef YSYX_24120013_PERF_EN
    do_reset();
    chk("perf_rst_cyc", cycle_cnt, 64'd0);
    chk("perf_rst_ret", instret_cnt, 64'd0);
    begin_run(3'd1);
    for (int i = 0; i < 40; i++) tick();
    chk("perf_state", state, 3'd1);
    chk("perf_instret", instret_cnt, 64'd10);
    chk("perf_cycle", cycle_cnt, 64'd40);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
